netclk_gen: RTL

//  Econet network clock generator: drives the netclk line when this station is clock master.

---
 rtl/netclk_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/netclk_gen.sv
// netclk_gen: Econet clock-master generator with glitch-free, period-aligned reconfiguration
module netclk_gen #(
    parameter int CNT_W      = 11,
    parameter int DEF_PERIOD = 200,
    parameter int DEF_LOW    = 20
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [CNT_W-1:0] period_in,
    input  logic [CNT_W-1:0] low_in,
    input  logic             cfg_load,
    output logic             cfg_ack,
    output logic             cfg_err,
    output logic             netclk_out,
    output logic             netclk_oe,
    output logic             cycle_start,
    output logic             running
);
    typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_e;
    state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, per_q, per_d, low_q, low_d, shp_q, shp_d, shl_q, shl_d;
    logic pend_q, pend_d, wrap, apply, cfg_ok, idle_load, busy_load;
    logic out_q, out_d, oe_q, oe_d, cs_q, cs_d, ack_q, ack_d, err_q, err_d, run_q, run_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            per_q   <= CNT_W'(DEF_PERIOD);
            low_q   <= CNT_W'(DEF_LOW);
            shp_q   <= '0;
            shl_q   <= '0;
            pend_q  <= 1'b0;
            out_q   <= 1'b1;
            oe_q    <= 1'b0;
            cs_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            low_q   <= low_d;
            shp_q   <= shp_d;
            shl_q   <= shl_d;
            pend_q  <= pend_d;
            out_q   <= out_d;
            oe_q    <= oe_d;
            cs_q    <= cs_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            run_q   <= run_d;
        end
    end

    // While idle a valid config goes live at once; otherwise it waits in the shadow for a boundary.
    always_comb begin
        cfg_ok    = period_in >= CNT_W'(4) && low_in != '0 && low_in <= period_in - CNT_W'(2);
        idle_load = cfg_load && cfg_ok && state_q == IDLE;
        busy_load = cfg_load && cfg_ok && state_q != IDLE;
        wrap      = state_q != IDLE && cnt_q == per_q - CNT_W'(1);
        apply     = wrap && pend_q;
        state_d   = state_q == IDLE ? (enable ? RUN : IDLE)
                  : state_q == RUN  ? (enable ? RUN : STOPPING)
                  : wrap            ? (enable ? RUN : IDLE) : STOPPING;
        cnt_d     = (state_q == IDLE || wrap) ? '0 : cnt_q + CNT_W'(1);
        per_d     = idle_load ? period_in : apply ? shp_q : per_q;
        low_d     = idle_load ? low_in : apply ? shl_q : low_q;
        shp_d     = busy_load ? period_in : shp_q;
        shl_d     = busy_load ? low_in : shl_q;
        pend_d    = busy_load ? 1'b1 : (apply || idle_load) ? 1'b0 : pend_q;
    end

    always_comb begin
        out_d = state_d == IDLE ? 1'b1 : cnt_d >= low_d;
        oe_d  = state_d != IDLE;
        run_d = state_d != IDLE;
        cs_d  = state_d != IDLE && cnt_d == '0;
        ack_d = apply || idle_load;
        err_d = cfg_load && !cfg_ok;
    end

    assign netclk_out  = out_q;
    assign netclk_oe   = oe_q;
    assign cycle_start = cs_q;
    assign cfg_ack     = ack_q;
    assign cfg_err     = err_q;
    assign running     = run_q;
endmodule
